periph_bridge: RTL and testbench
================================

PERIPH_BRIDGE -- requirements
Module: periph_bridge

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of every data word in both directions.
REQ-002 Parameter FIFO_DEPTH, default 8, power of two and at least 2: number of core-to-host result entries.
REQ-003 Parameter GAP_CYCLES, default 2, range 0-15: idle cycles enforced after each host-to-core send.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 to_peripheral  input  2  message type from the core.
REQ-007 to_peripheral_data  input  DATA_WIDTH  message payload from the core.
REQ-008 to_peripheral_valid  input  1  core message present this cycle; there is no back-pressure to the core.
REQ-009 from_peripheral  output  2  message type to the core.
REQ-010 from_peripheral_data  output  DATA_WIDTH  message payload to the core.
REQ-011 from_peripheral_valid  output  1  one-cycle pulse marking a message to the core.
REQ-012 host_cmd_valid / host_cmd_ready  input / output  1 / 1  host-to-core command handshake.
REQ-013 host_cmd_type / host_cmd_data  input / input  2 / DATA_WIDTH  command contents.
REQ-014 host_rsp_valid / host_rsp_ready  output / input  1 / 1  core-to-host result handshake.
REQ-015 host_rsp_type / host_rsp_data  output / output  2 / DATA_WIDTH  FIFO head entry.
REQ-016 rsp_count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-017 overflow  output  1  sticky flag: a core message was dropped.
REQ-018 drop_count  output  16  number of dropped core messages (see Configuration).

Function
REQ-019 Receive path:
- A push occurs in every cycle with to_peripheral_valid=1.
- Each push stores {to_peripheral, to_peripheral_data} at the FIFO tail.
REQ-020 The FIFO is first-word-fall-through:
- An entry pushed at edge N is presented on host_rsp_* with host_rsp_valid=1 after edge N when the FIFO was empty.
- host_rsp_valid = (rsp_count != 0).
REQ-021 A pop occurs when host_rsp_valid and host_rsp_ready are both 1; the next entry is presented in the following cycle.
REQ-022 Push and pop in the same cycle:
- Both take effect and rsp_count is unchanged, including when the FIFO is full.
REQ-023 Push while full with no pop:
- The message is dropped and FIFO contents are unchanged.
- overflow is set to 1 and stays 1 until reset.
REQ-024 Pointers wrap modulo FIFO_DEPTH; rsp_count never exceeds FIFO_DEPTH and never goes below 0.
REQ-025 host_rsp_ready is ignored while the FIFO is empty.
REQ-026 Send FSM states are IDLE, DRIVE and GAP.
- host_cmd_ready = 1 only in IDLE.
REQ-027 In IDLE with host_cmd_valid=1:
- host_cmd_type and host_cmd_data are registered into from_peripheral and from_peripheral_data.
- The FSM enters DRIVE.
REQ-028 In DRIVE, from_peripheral_valid=1 for exactly one cycle.
- Next state is GAP with the counter loaded to GAP_CYCLES-1.
- If GAP_CYCLES=0, next state is IDLE.
REQ-029 GAP counts down once per cycle and returns to IDLE in the cycle after the counter reads 0.
- Back-to-back valid pulses are therefore separated by at least GAP_CYCLES+1 cycles.
REQ-030 from_peripheral and from_peripheral_data hold their last sent value outside DRIVE.
REQ-031 The receive and send paths are fully independent and may be active in the same cycle.

Reset
REQ-032 While reset=1 at a clock edge:
- The FIFO is emptied, so rsp_count=0 and host_rsp_valid=0.
- overflow=0, drop_count=0, FSM=IDLE.
- from_peripheral=0, from_peripheral_data=0, from_peripheral_valid=0.
REQ-033 Reset asserted mid-send (in DRIVE or GAP) aborts the send.
- from_peripheral_valid=0 in the cycle after the reset edge.
- host_cmd_ready=1 once reset is released.
REQ-034 to_peripheral_valid and host_cmd_valid are ignored during any cycle with reset=1.

Configuration
REQ-035 With PERIPH_BRIDGE_DROP_COUNT_EN defined:
- drop_count increments by 1 on every dropped message.
- drop_count saturates at 16'hFFFF.
REQ-036 Without PERIPH_BRIDGE_DROP_COUNT_EN, drop_count is tied to 0 and no counter logic is present; overflow behaves identically in both builds.

Verification
REQ-037 Fill test: reset, then push 0x11, 0x22, 0x33 with type 0 on consecutive cycles, host_rsp_ready=0.
- Required: rsp_count=3; head shows 0x11.
- With ready=1, pops yield 0x11, 0x22, 0x33 in order, then host_rsp_valid=0.
REQ-038 Overflow test (DEPTH=8): push 9 words 1..9 with no pops.
- Required: rsp_count=8, overflow=1, drop_count=1 (macro on) or 0 (macro off).
- Draining yields 1..8.
REQ-039 Full push+pop test: with the FIFO full, push 0xAA and pop in the same cycle.
- Required: rsp_count stays 8, overflow stays 0, and 0xAA is the last entry drained.
REQ-040 Send test (GAP_CYCLES=2): hold host_cmd_valid=1 with type 2, data 0xDEADBEEF.
- Required: one from_peripheral_valid pulse carrying 2/0xDEADBEEF.
- host_cmd_ready returns to 1 three cycles after the pulse.
- The next pulse occurs no sooner than 3 cycles after the previous one.
REQ-041 Reset mid-send: assert reset during DRIVE.
- Required: from_peripheral_valid=0, from_peripheral_data=0 and rsp_count=0 after the edge.
- host_cmd_ready=1 after release.
REQ-042 Wrap test: 20 pushes interleaved with pops, keeping occupancy between 1 and 3.
- Required: output order equals input order across pointer wrap; overflow=0.

Source files
------------

// File: rtl/periph_bridge.sv
// periph_bridge: couples a core message port to a host command/response pair.
//   Receive path: every core message is pushed into a first-word-fall-through
//   FIFO that the host drains with a valid/ready handshake.
//   Send path: an IDLE/DRIVE/GAP FSM forwards one host command to the core as a
//   single-cycle pulse, then enforces GAP_CYCLES idle cycles.
// Optional feature macro: PERIPH_BRIDGE_DROP_COUNT_EN adds a saturating 16-bit
// count of dropped core messages; without it drop_count is tied to zero.
module periph_bridge #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [1:0]                    to_peripheral,
   input  logic [DATA_WIDTH-1:0]         to_peripheral_data,
   input  logic                          to_peripheral_valid,
   output logic [1:0]                    from_peripheral,
   output logic [DATA_WIDTH-1:0]         from_peripheral_data,
   output logic                          from_peripheral_valid,
   input  logic                          host_cmd_valid,
   output logic                          host_cmd_ready,
   input  logic [1:0]                    host_cmd_type,
   input  logic [DATA_WIDTH-1:0]         host_cmd_data,
   output logic                          host_rsp_valid,
   input  logic                          host_rsp_ready,
   output logic [1:0]                    host_rsp_type,
   output logic [DATA_WIDTH-1:0]         host_rsp_data,
   output logic [$clog2(FIFO_DEPTH):0]   rsp_count,
   output logic                          overflow,
   output logic [15:0]                   drop_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_WIDTH + 2;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
   localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

   // ---------------- receive FIFO ----------------
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          overflow_reg;
   logic          push, pop, full, accept, drop;

   // A pop frees a slot in the same cycle, so a push into a full FIFO with a
   // simultaneous pop is accepted rather than dropped.
   assign full   = (count_reg == FULL_CNT);
   assign push   = to_peripheral_valid;
   assign pop    = (count_reg != '0) && host_rsp_ready;
   assign accept = push && (!full || pop);
   assign drop   = push && full && !pop;

   // Storage array: written only on accepted pushes, never reset.
   always_ff @(posedge clock) begin
      if (!reset && accept)
         mem[wr_ptr_reg] <= {to_peripheral, to_peripheral_data};
   end

   // Pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (accept && !pop)      count_reg <= count_reg + 1'b1;
         else if (!accept && pop) count_reg <= count_reg - 1'b1;
         if (drop) overflow_reg <= 1'b1;
      end
   end

   assign host_rsp_valid = (count_reg != '0);
   assign host_rsp_type  = mem[rd_ptr_reg][EW-1 -: 2];
   assign host_rsp_data  = mem[rd_ptr_reg][DATA_WIDTH-1:0];
   assign rsp_count      = count_reg;
   assign overflow       = overflow_reg;

`ifdef PERIPH_BRIDGE_DROP_COUNT_EN
   logic [15:0] drop_count_reg;

   // Saturating count of dropped core messages.
   always_ff @(posedge clock) begin
      if (reset)
         drop_count_reg <= '0;
      else if (drop && drop_count_reg != 16'hFFFF)
         drop_count_reg <= drop_count_reg + 16'd1;
   end

   assign drop_count = drop_count_reg;
`else
   assign drop_count = '0;
`endif

   // ---------------- send FSM ----------------
   typedef enum logic [1:0] {IDLE, DRIVE, GAP} send_state_t;

   send_state_t           state_reg;
   logic [3:0]            gap_cnt_reg;
   logic [1:0]            type_reg;
   logic [DATA_WIDTH-1:0] data_reg;
   logic                  valid_reg;

   // Command capture, one-cycle pulse while in DRIVE, then the enforced gap.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg   <= IDLE;
         gap_cnt_reg <= '0;
         type_reg    <= '0;
         data_reg    <= '0;
         valid_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (host_cmd_valid) begin
                  type_reg  <= host_cmd_type;
                  data_reg  <= host_cmd_data;
                  valid_reg <= 1'b1;
                  state_reg <= DRIVE;
               end
            end
            DRIVE: begin
               valid_reg   <= 1'b0;
               gap_cnt_reg <= GAP_LOAD;
               state_reg   <= (GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP: begin
               if (gap_cnt_reg == '0)
                  state_reg <= IDLE;
               else
                  gap_cnt_reg <= gap_cnt_reg - 4'd1;
            end
            default: begin
               valid_reg <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign host_cmd_ready        = (state_reg == IDLE);
   assign from_peripheral       = type_reg;
   assign from_peripheral_data  = data_reg;
   assign from_peripheral_valid = valid_reg;

endmodule

// File: tb/tb_periph_bridge.sv
// Directed testbench for periph_bridge (DATA_WIDTH=32, FIFO_DEPTH=8, GAP_CYCLES=2).
// Works with or without PERIPH_BRIDGE_DROP_COUNT_EN defined.
module tb_periph_bridge;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  to_peripheral;
   logic [31:0] to_peripheral_data;
   logic        to_peripheral_valid;
   logic [1:0]  from_peripheral;
   logic [31:0] from_peripheral_data;
   logic        from_peripheral_valid;
   logic        host_cmd_valid;
   logic        host_cmd_ready;
   logic [1:0]  host_cmd_type;
   logic [31:0] host_cmd_data;
   logic        host_rsp_valid;
   logic        host_rsp_ready;
   logic [1:0]  host_rsp_type;
   logic [31:0] host_rsp_data;
   logic [3:0]  rsp_count;
   logic        overflow;
   logic [15:0] drop_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_q[$];
   logic [31:0] exp_word;

`ifdef PERIPH_BRIDGE_DROP_COUNT_EN
   localparam logic [15:0] EXP_DROP = 16'd1;
`else
   localparam logic [15:0] EXP_DROP = 16'd0;
`endif

   periph_bridge #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .GAP_CYCLES(2)) dut (
      .clock(clock), .reset(reset),
      .to_peripheral(to_peripheral), .to_peripheral_data(to_peripheral_data),
      .to_peripheral_valid(to_peripheral_valid),
      .from_peripheral(from_peripheral), .from_peripheral_data(from_peripheral_data),
      .from_peripheral_valid(from_peripheral_valid),
      .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
      .host_cmd_type(host_cmd_type), .host_cmd_data(host_cmd_data),
      .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
      .host_rsp_type(host_rsp_type), .host_rsp_data(host_rsp_data),
      .rsp_count(rsp_count), .overflow(overflow), .drop_count(drop_count)
   );

   always #5 clock = ~clock;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] w);
      to_peripheral       = 2'd0;
      to_peripheral_data  = w;
      to_peripheral_valid = 1'b1;
      tick();
      to_peripheral_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      to_peripheral = '0; to_peripheral_data = '0; to_peripheral_valid = 1'b0;
      host_cmd_valid = 1'b0; host_cmd_type = '0; host_cmd_data = '0;
      host_rsp_ready = 1'b0;
      #1;
      do_reset();

      // Reset state
      check_value("rst_count", 64'(rsp_count), 64'd0);
      check_value("rst_rsp_valid", 64'(host_rsp_valid), 64'd0);
      check_value("rst_overflow", 64'(overflow), 64'd0);
      check_value("rst_drop", 64'(drop_count), 64'd0);
      check_value("rst_cmd_ready", 64'(host_cmd_ready), 64'd1);
      check_value("rst_fp_valid", 64'(from_peripheral_valid), 64'd0);
      check_value("rst_fp_data", 64'(from_peripheral_data), 64'd0);

      // Fill test
      push_word(32'h11); push_word(32'h22); push_word(32'h33);
      check_value("fill_count", 64'(rsp_count), 64'd3);
      check_value("fill_head", 64'(host_rsp_data), 64'h11);
      check_value("fill_rsp_valid", 64'(host_rsp_valid), 64'd1);
      host_rsp_ready = 1'b1;
      check_value("fill_pop0", 64'(host_rsp_data), 64'h11); tick();
      check_value("fill_pop1", 64'(host_rsp_data), 64'h22); tick();
      check_value("fill_pop2", 64'(host_rsp_data), 64'h33); tick();
      check_value("fill_empty_valid", 64'(host_rsp_valid), 64'd0);
      tick();  // ready held high while empty must be harmless
      check_value("fill_empty_count", 64'(rsp_count), 64'd0);
      host_rsp_ready = 1'b0;

      // Overflow test
      for (int i = 1; i <= 9; i++) push_word(32'(i));
      check_value("ovf_count", 64'(rsp_count), 64'd8);
      check_value("ovf_flag", 64'(overflow), 64'd1);
      check_value("ovf_drop", 64'(drop_count), 64'(EXP_DROP));
      host_rsp_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check_value($sformatf("ovf_drain%0d", i), 64'(host_rsp_data), 64'(i));
         tick();
      end
      check_value("ovf_drained_valid", 64'(host_rsp_valid), 64'd0);
      check_value("ovf_sticky", 64'(overflow), 64'd1);
      host_rsp_ready = 1'b0;

      // Full push+pop test
      do_reset();
      for (int i = 1; i <= 8; i++) push_word(32'(i));
      to_peripheral_data = 32'hAA; to_peripheral_valid = 1'b1; host_rsp_ready = 1'b1;
      check_value("fpp_head", 64'(host_rsp_data), 64'd1);
      tick();
      to_peripheral_valid = 1'b0;
      check_value("fpp_count", 64'(rsp_count), 64'd8);
      check_value("fpp_overflow", 64'(overflow), 64'd0);
      for (int i = 2; i <= 8; i++) begin
         check_value($sformatf("fpp_drain%0d", i), 64'(host_rsp_data), 64'(i));
         tick();
      end
      check_value("fpp_last", 64'(host_rsp_data), 64'hAA);
      tick();
      check_value("fpp_empty", 64'(rsp_count), 64'd0);
      host_rsp_ready = 1'b0;

      // Wrap test: occupancy held at 2 while pointers wrap
      model_q.delete();
      for (int i = 0; i < 2; i++) begin
         model_q.push_back(32'h100 + 32'(i));
         push_word(32'h100 + 32'(i));
      end
      for (int i = 2; i < 20; i++) begin
         to_peripheral_data = 32'h100 + 32'(i); to_peripheral_valid = 1'b1;
         host_rsp_ready = 1'b1;
         exp_word = model_q.pop_front();
         model_q.push_back(32'h100 + 32'(i));
         check_value($sformatf("wrap_out%0d", i - 2), 64'(host_rsp_data), 64'(exp_word));
         tick();
         check_value($sformatf("wrap_cnt%0d", i - 2), 64'(rsp_count), 64'd2);
      end
      to_peripheral_valid = 1'b0;
      while (model_q.size() > 0) begin
         exp_word = model_q.pop_front();
         check_value("wrap_tail", 64'(host_rsp_data), 64'(exp_word));
         tick();
      end
      check_value("wrap_overflow", 64'(overflow), 64'd0);
      check_value("wrap_empty", 64'(host_rsp_valid), 64'd0);
      host_rsp_ready = 1'b0;

      // Send test: command held continuously
      host_cmd_type = 2'd2; host_cmd_data = 32'hDEADBEEF; host_cmd_valid = 1'b1;
      tick();  // t1: DRIVE
      check_value("send_pulse", 64'(from_peripheral_valid), 64'd1);
      check_value("send_type", 64'(from_peripheral), 64'd2);
      check_value("send_data", 64'(from_peripheral_data), 64'hDEADBEEF);
      check_value("send_ready_t1", 64'(host_cmd_ready), 64'd0);
      tick();  // t2
      check_value("send_valid_t2", 64'(from_peripheral_valid), 64'd0);
      check_value("send_ready_t2", 64'(host_cmd_ready), 64'd0);
      tick();  // t3
      check_value("send_valid_t3", 64'(from_peripheral_valid), 64'd0);
      check_value("send_ready_t3", 64'(host_cmd_ready), 64'd0);
      check_value("send_hold_t3", 64'(from_peripheral_data), 64'hDEADBEEF);
      tick();  // t4: back in IDLE
      check_value("send_valid_t4", 64'(from_peripheral_valid), 64'd0);
      check_value("send_ready_t4", 64'(host_cmd_ready), 64'd1);
      tick();  // t5: second pulse
      check_value("send_pulse2", 64'(from_peripheral_valid), 64'd1);
      host_cmd_valid = 1'b0;

      // Reset mid-send
      for (int i = 0; i < 10 && !host_cmd_ready; i++) tick();
      check_value("rms_idle", 64'(host_cmd_ready), 64'd1);
      host_cmd_type = 2'd1; host_cmd_data = 32'h12345678; host_cmd_valid = 1'b1;
      to_peripheral_data = 32'h5; to_peripheral_valid = 1'b1;
      tick();
      host_cmd_valid = 1'b0; to_peripheral_valid = 1'b0;
      check_value("rms_drive", 64'(from_peripheral_valid), 64'd1);
      check_value("rms_count_pre", 64'(rsp_count), 64'd1);
      reset = 1'b1; to_peripheral_valid = 1'b1; host_cmd_valid = 1'b1;
      tick();
      check_value("rms_valid", 64'(from_peripheral_valid), 64'd0);
      check_value("rms_data", 64'(from_peripheral_data), 64'd0);
      check_value("rms_type", 64'(from_peripheral), 64'd0);
      check_value("rms_count", 64'(rsp_count), 64'd0);
      reset = 1'b0; to_peripheral_valid = 1'b0; host_cmd_valid = 1'b0;
      tick();
      check_value("rms_ready", 64'(host_cmd_ready), 64'd1);
      check_value("rms_count_post", 64'(rsp_count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
